// File: rtl/code_entry_sequencer_pkg.sv
// Shared definitions for the keypad code-entry sequencer: FSM states,
// checker terminal states, result codes, special key codes and small helpers.
// No ports; imported by the sequencer top and its synchronizer.
package code_entry_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_DEBOUNCE     = 3'd1,
        ST_ISSUE        = 3'd2,
        ST_CHECK        = 3'd3,
        ST_WAIT_RELEASE = 3'd4,
        ST_CLEAR        = 3'd5,
        ST_DONE         = 3'd6,
        ST_LOCKED       = 3'd7
    } state_e;

    // Checker states that end an attempt
    localparam logic [3:0] CHK_TOTAL   = 4'b0110;
    localparam logic [3:0] CHK_PARTIAL = 4'b1110;
    localparam logic [3:0] CHK_FAIL    = 4'b1111;

    // Values driven on the result output
    localparam logic [1:0] RES_BUSY    = 2'b00;
    localparam logic [1:0] RES_TOTAL   = 2'b01;
    localparam logic [1:0] RES_PARTIAL = 2'b10;
    localparam logic [1:0] RES_FAIL    = 2'b11;

    // Keys with a control meaning; A-D are accepted but do nothing
    localparam logic [3:0] KEY_CLEAR   = 4'hE;
    localparam logic [3:0] KEY_RESTART = 4'hF;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

endpackage

// File: rtl/code_entry_sequencer_key_sync.sv
// Two-flop synchronizer bringing the raw keypad level and code into clk.
// Latency: 2 cycles. No backpressure; samples every cycle.
// Ports: clk, reset (async high), key_valid/key_code raw in, *_s synchronized out.
module code_entry_sequencer_key_sync
    import code_entry_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_valid_s,
    output logic [3:0] key_code_s
);

    logic [4:0] meta_q, meta_d;
    logic [4:0] sync_q, sync_d;

    always_comb begin
        meta_d = {key_valid, key_code};
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign key_valid_s = sync_q[4];
    assign key_code_s  = sync_q[3:0];

endmodule

// File: rtl/code_entry_sequencer.sv
// Debounces keypad presses into single insere strobes for the code checker,
// watches the checker outcome, handles inter-digit timeout, clear/restart and
// lockout after repeated failures. Latency: press to insere is 2 sync cycles
// + DEBOUNCE_CYCLES + 1. No backpressure; keys outside accepting states are ignored.
// Ports: clk, reset (async high); key_valid/key_code raw keypad; chk_estado
// checker state; insere/numero digit strobe; chk_rst checker clear;
// result/fails/lockout status.
module code_entry_sequencer
    import code_entry_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 5000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] chk_estado,
    output logic       insere,
    output logic [3:0] numero,
    output logic       chk_rst,
    output logic [1:0] result,
    output logic [1:0] fails,
    output logic       lockout
);

    // Terminal timer values: each condition is met on its Nth cycle in-state
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic       kv_s;
    logic [3:0] kc_s;

    code_entry_sequencer_key_sync u_key_sync (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_valid_s (kv_s),
        .key_code_s  (kc_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       numero_q, numero_d;
    logic [2:0]       digit_cnt_q, digit_cnt_d;
    logic [1:0]       result_q, result_d;
    logic [1:0]       fails_q, fails_d;
    logic [1:0]       fails_inc;

    assign fails_inc = sat_inc2(fails_q);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        code_d      = code_q;
        numero_d    = numero_q;
        digit_cnt_d = digit_cnt_q;
        result_d    = result_q;
        fails_d     = fails_q;

        case (state_q)
            ST_IDLE: begin
                // Timeout is tested first so it wins over a simultaneous press
                if ((digit_cnt_q != 3'd0) && (timer_q == TO_LAST)) begin
                    state_d = ST_CLEAR;
                end else if (kv_s) begin
                    state_d = ST_DEBOUNCE;
                    code_d  = kc_s;
                end else if (digit_cnt_q != 3'd0) begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (!kv_s || (kc_s != code_q)) begin
                    state_d = ST_IDLE;
                end else if (timer_q == DEB_LAST) begin
                    if (is_digit(code_q)) begin
                        state_d  = ST_ISSUE;
                        numero_d = code_q;
                    end else if (code_q == KEY_CLEAR) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_WAIT_RELEASE;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_ISSUE: begin
                digit_cnt_d = (digit_cnt_q == 3'd7) ? 3'd7 : digit_cnt_q + 3'd1;
                state_d     = ST_CHECK;
            end

            ST_CHECK: begin
                // Checker has already absorbed the digit strobed on the last edge
                case (chk_estado)
                    CHK_TOTAL: begin
                        result_d = RES_TOTAL;
                        fails_d  = 2'd0;
                        state_d  = ST_DONE;
                    end
                    CHK_PARTIAL: begin
                        result_d = RES_PARTIAL;
                        fails_d  = 2'd0;
                        state_d  = ST_DONE;
                    end
                    CHK_FAIL: begin
                        result_d = RES_FAIL;
                        fails_d  = fails_inc;
                        state_d  = (int'(fails_inc) >= MAX_FAILS) ? ST_LOCKED : ST_DONE;
                    end
                    default: state_d = ST_WAIT_RELEASE;
                endcase
            end

            ST_WAIT_RELEASE: begin
                if (kv_s) begin
                    timer_d = '0;
                end else if (timer_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_CLEAR: begin
                digit_cnt_d = 3'd0;
                result_d    = RES_BUSY;
                state_d     = ST_WAIT_RELEASE;
            end

            ST_DONE: begin
                // Only a stable F leaves; any other key or a release restarts the count
                if (kv_s && (kc_s == KEY_RESTART)) begin
                    if (timer_q == DEB_LAST) begin
                        state_d = ST_CLEAR;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end

            ST_LOCKED: begin
                if (timer_q == LOCK_LAST) begin
                    fails_d = 2'd0;
                    state_d = ST_CLEAR;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // One timer serves every state, so each state starts counting from zero
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            code_q      <= '0;
            numero_q    <= '0;
            digit_cnt_q <= '0;
            result_q    <= '0;
            fails_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            code_q      <= code_d;
            numero_q    <= numero_d;
            digit_cnt_q <= digit_cnt_d;
            result_q    <= result_d;
            fails_q     <= fails_d;
        end
    end

    assign insere  = (state_q == ST_ISSUE);
    assign chk_rst = (state_q == ST_CLEAR);
    assign lockout = (state_q == ST_LOCKED);
    assign numero  = numero_q;
    assign result  = result_q;
    assign fails   = fails_q;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Self-checking bench for code_entry_sequencer with a small checker model.
// Expected digits are queued when pressed and matched against insere strobes.
// Scenario tasks check status outputs, clear pulses, timeout and lockout.
module tb_code_entry_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] chk_estado;
    logic       insere;
    logic [3:0] numero;
    logic       chk_rst;
    logic [1:0] result;
    logic [1:0] fails;
    logic       lockout;

    code_entry_sequencer #(
        .DEBOUNCE_CYCLES (16),
        .TIMEOUT_CYCLES  (1000),
        .MAX_FAILS       (3),
        .LOCKOUT_CYCLES  (5000),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .chk_estado (chk_estado),
        .insere     (insere),
        .numero     (numero),
        .chk_rst    (chk_rst),
        .result     (result),
        .fails      (fails),
        .lockout    (lockout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    int ins_cnt = 0;
    int rst_cnt = 0;
    int lock_run = 0;
    int lock_len = 0;

    // Checker model: terminal state after the term_at-th digit, else a busy state
    int         term_at = 0;
    logic [3:0] term_val = 4'h0;
    int         k = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= 0;
            chk_estado <= 4'h0;
        end else if (chk_rst) begin
            k <= 0;
            chk_estado <= 4'h0;
        end else if (insere) begin
            k <= k + 1;
            chk_estado <= (k + 1 == term_at) ? term_val : 4'b0001;
        end
    end

    // Scoreboard monitor and pulse/lockout counters
    always @(negedge clk) begin
        if (insere === 1'b1) begin
            ins_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_insere: numero=%0h, no digit expected", numero);
            end else begin
                mon_exp = exp_q.pop_front();
                if (numero !== mon_exp) begin
                    errors++;
                    $display("FAIL insere_numero: got %0h expected %0h", numero, mon_exp);
                end
            end
        end
        if (chk_rst === 1'b1) rst_cnt++;
        if (lockout === 1'b1) lock_run++;
        else if (lock_run != 0) begin
            lock_len = lock_run;
            lock_run = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] c, input bit expect_ins, input int hold, input int rel);
        if (expect_ins) exp_q.push_back(c);
        key_code  = c;
        key_valid = 1'b1;
        cyc(hold);
        key_valid = 1'b0;
        cyc(rel);
    endtask

    task automatic test_reset();
        cyc(3);
        checks++;
        if ({insere, chk_rst, lockout, result, fails, numero} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {insere, chk_rst, lockout, result, fails, numero});
        end
        reset = 1'b0;
        cyc(5);
        checks++;
        if ({insere, chk_rst, lockout, result, fails, numero} !== 13'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected all zero",
                     {insere, chk_rst, lockout, result, fails, numero});
        end
    endtask

    task automatic test_success();
        logic [3:0] seq [6] = '{4'd5, 4'd8, 4'd9, 4'd2, 4'd0, 4'd4};
        int base;
        term_at = 6; term_val = 4'b0110;
        base = ins_cnt;
        foreach (seq[i]) press(seq[i], 1'b1, 40, 40);
        checks++;
        if (ins_cnt - base != 6) begin
            errors++; $display("FAIL success_inserts: got %0d expected 6", ins_cnt - base);
        end
        checks++;
        if (result !== 2'b01) begin
            errors++; $display("FAIL success_result: got %b expected 01", result);
        end
        checks++;
        if (fails !== 2'd0) begin
            errors++; $display("FAIL success_fails: got %0d expected 0", fails);
        end
    endtask

    task automatic test_done_ignores();
        int base, rb;
        base = ins_cnt;
        press(4'd1, 1'b0, 40, 40);
        checks++;
        if (ins_cnt != base || result !== 2'b01) begin
            errors++;
            $display("FAIL done_ignore: inserts %0d result %b expected 0 and 01", ins_cnt - base, result);
        end
        rb = rst_cnt;
        press(4'hF, 1'b0, 40, 40);
        checks++;
        if (rst_cnt - rb != 1 || result !== 2'b00) begin
            errors++;
            $display("FAIL restart_clear: chk_rst %0d result %b expected 1 and 00", rst_cnt - rb, result);
        end
    endtask

    task automatic test_partial();
        logic [3:0] seq [7] = '{4'd3, 4'd5, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};
        int base;
        term_at = 7; term_val = 4'b1110;
        base = ins_cnt;
        foreach (seq[i]) press(seq[i], 1'b1, 40, 40);
        checks++;
        if (ins_cnt - base != 7) begin
            errors++; $display("FAIL partial_inserts: got %0d expected 7", ins_cnt - base);
        end
        checks++;
        if (result !== 2'b10) begin
            errors++; $display("FAIL partial_result: got %b expected 10", result);
        end
        press(4'hF, 1'b0, 40, 40);
    endtask

    task automatic test_fail_lockout();
        int n;
        term_at = 2; term_val = 4'b1111;
        for (int a = 1; a <= 3; a++) begin
            press(4'd3, 1'b1, 40, 40);
            press(4'd7, 1'b1, 40, 40);
            if (a < 3) begin
                checks++;
                if (result !== 2'b11 || fails !== 2'(a)) begin
                    errors++;
                    $display("FAIL fail_attempt%0d: result %b fails %0d expected 11 and %0d", a, result, fails, a);
                end
                press(4'hF, 1'b0, 40, 40);
                checks++;
                if (result !== 2'b00) begin
                    errors++; $display("FAIL fail_clear%0d: result %b expected 00", a, result);
                end
            end
        end
        checks++;
        if (lockout !== 1'b1 || fails !== 2'd3) begin
            errors++;
            $display("FAIL lockout_entry: lockout %b fails %0d expected 1 and 3", lockout, fails);
        end
        n = 0;
        while (lockout === 1'b1 && n < 6000) begin
            cyc(1);
            n++;
        end
        checks++;
        if (lockout !== 1'b0 || chk_rst !== 1'b1 || fails !== 2'd0) begin
            errors++;
            $display("FAIL lockout_exit: lockout %b chk_rst %b fails %0d expected 0 1 0", lockout, chk_rst, fails);
        end
        cyc(1);
        checks++;
        if (lock_len != 5000) begin
            errors++; $display("FAIL lockout_length: got %0d expected 5000", lock_len);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] seq [6] = '{4'd5, 4'd8, 4'd9, 4'd2, 4'd0, 4'd4};
        int rb, n;
        cyc(20);
        term_at = 2; term_val = 4'b1111;
        press(4'd3, 1'b1, 40, 40);
        press(4'd7, 1'b1, 40, 40);
        press(4'hF, 1'b0, 40, 40);
        term_at = 0;
        press(4'd5, 1'b1, 40, 40);
        rb = rst_cnt;
        cyc(900);
        checks++;
        if (rst_cnt != rb) begin
            errors++; $display("FAIL timeout_early: chk_rst %0d pulses expected 0", rst_cnt - rb);
        end
        n = 0;
        while (rst_cnt == rb && n < 200) begin
            cyc(1);
            n++;
        end
        checks++;
        if (rst_cnt - rb != 1) begin
            errors++; $display("FAIL timeout_clear: chk_rst %0d pulses expected 1", rst_cnt - rb);
        end
        checks++;
        if (fails !== 2'd1 || result !== 2'b00) begin
            errors++; $display("FAIL timeout_status: fails %0d result %b expected 1 and 00", fails, result);
        end
        cyc(40);
        term_at = 6; term_val = 4'b0110;
        foreach (seq[i]) press(seq[i], 1'b1, 40, 40);
        checks++;
        if (result !== 2'b01 || fails !== 2'd0) begin
            errors++; $display("FAIL timeout_restart: result %b fails %0d expected 01 and 0", result, fails);
        end
        press(4'hF, 1'b0, 40, 40);
    endtask

    task automatic test_glitch();
        int base;
        term_at = 0;
        base = ins_cnt;
        key_code = 4'd1; key_valid = 1'b1; cyc(10);
        key_valid = 1'b0; cyc(40);
        key_code = 4'd3; key_valid = 1'b1; cyc(10);
        key_code = 4'd4; cyc(10);
        key_valid = 1'b0; cyc(40);
        checks++;
        if (ins_cnt != base) begin
            errors++; $display("FAIL glitch_rejected: got %0d inserts expected 0", ins_cnt - base);
        end
        press(4'd5, 1'b1, 500, 40);
        checks++;
        if (ins_cnt - base != 1) begin
            errors++; $display("FAIL long_hold: got %0d inserts expected 1", ins_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        key_code = 4'd2; key_valid = 1'b1;
        cyc(10);
        reset = 1'b1;
        cyc(1);
        checks++;
        if ({insere, chk_rst, lockout, result, fails, numero} !== 13'd0) begin
            errors++;
            $display("FAIL reset_in_debounce: got %b expected all zero",
                     {insere, chk_rst, lockout, result, fails, numero});
        end
        key_valid = 1'b0;
        cyc(3);
        reset = 1'b0;
        base = ins_cnt;
        cyc(60);
        checks++;
        if (ins_cnt != base) begin
            errors++; $display("FAIL reset_no_insere: got %0d inserts expected 0", ins_cnt - base);
        end
        term_at = 2; term_val = 4'b1111;
        for (int a = 0; a < 3; a++) begin
            press(4'd3, 1'b1, 40, 40);
            press(4'd7, 1'b1, 40, 40);
            if (a < 2) press(4'hF, 1'b0, 40, 40);
        end
        checks++;
        if (lockout !== 1'b1) begin
            errors++; $display("FAIL relock: lockout %b expected 1", lockout);
        end
        cyc(100);
        reset = 1'b1;
        cyc(1);
        checks++;
        if ({insere, chk_rst, lockout, result, fails} !== 9'd0) begin
            errors++;
            $display("FAIL reset_in_lockout: got %b expected all zero",
                     {insere, chk_rst, lockout, result, fails});
        end
        reset = 1'b0;
        cyc(100);
        checks++;
        if (lockout !== 1'b0 || fails !== 2'd0) begin
            errors++; $display("FAIL lockout_aborted: lockout %b fails %0d expected 0 and 0", lockout, fails);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d digits never strobed expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_success();
        test_done_ignores();
        test_partial();
        test_fail_lockout();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
